// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning bit-reversed FFT output into natural order
module fft_out_reorder #(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_push,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          in_stall,
  output logic          out_push_F,
  output logic [DW-1:0] out_real_F,
  output logic [DW-1:0] out_imag_F,
  output logic          out_last_F,
  input  logic          out_stall
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  // The read side is draining exactly when its current bank holds a complete frame.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  logic [2*DW-1:0]  mem [2][N];

  logic             wr_bank, wr_bank_d;
  logic [LOG2N-1:0] wr_idx, wr_idx_d;
  logic             rd_bank, rd_bank_d;
  logic [LOG2N-1:0] rd_idx, rd_idx_d;
  logic [1:0]       bank_full, bank_full_d;
  rd_state_t        rd_state;
  logic             wr_en;
  logic             rd_en;
  logic [2*DW-1:0]  rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Stall depends on registers only, so upstream sees no combinational path from our inputs.
  assign in_stall = bank_full[wr_bank];
  assign rd_word  = mem[rd_bank][rd_idx];

  // Next-state: write pointer, read pointer and per-bank full flags.
  always_comb begin
    wr_bank_d   = wr_bank;
    wr_idx_d    = wr_idx;
    rd_bank_d   = rd_bank;
    rd_idx_d    = rd_idx;
    bank_full_d = bank_full;
    rd_state    = bank_full[rd_bank] ? DRAIN : IDLE;
    wr_en       = in_push && !in_stall;
    rd_en       = (rd_state == DRAIN) && !out_stall;

    if (wr_en) begin
      wr_idx_d = wr_idx + LOG2N'(1);
      if (wr_idx == LAST_IDX) begin
        bank_full_d[wr_bank] = 1'b1;
        wr_bank_d            = ~wr_bank;
      end
    end

    // Writer and reader never share a bank, so both flag updates can land together.
    if (rd_en) begin
      rd_idx_d = rd_idx + LOG2N'(1);
      if (rd_idx == LAST_IDX) begin
        bank_full_d[rd_bank] = 1'b0;
        rd_bank_d            = ~rd_bank;
      end
    end
  end

  // Pointer and flag registers; reset discards any partial or full frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      bank_full <= 2'b00;
    end else begin
      wr_bank   <= wr_bank_d;
      wr_idx    <= wr_idx_d;
      rd_bank   <= rd_bank_d;
      rd_idx    <= rd_idx_d;
      bank_full <= bank_full_d;
    end
  end

  // Sample storage: scatter at the bit-reversed index, no reset on contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][bitrev(wr_idx)] <= {in_real, in_imag};
    end
  end

  // Registered output stage; data and last hold their value while no sample is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_push_F <= 1'b0;
      out_real_F <= '0;
      out_imag_F <= '0;
      out_last_F <= 1'b0;
    end else if (rd_en) begin
      out_push_F <= 1'b1;
      out_real_F <= rd_word[2*DW-1:DW];
      out_imag_F <= rd_word[DW-1:0];
      out_last_F <= (rd_idx == LAST_IDX);
    end else begin
      out_push_F <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - directed self-checking bench for fft_out_reorder
module tb_fft_out_reorder;

  logic        clk;
  logic        reset;
  logic        in_push;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        in_stall;
  logic        out_push_F;
  logic [15:0] out_real_F;
  logic [15:0] out_imag_F;
  logic        out_last_F;
  logic        out_stall;

  int total = 0;
  int bad   = 0;

  // Natural-order position k holds the sample that arrived k-bit-reversed.
  int tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [15:0] src_real [$];
  logic [15:0] src_imag [$];
  logic        rec_push [$];
  logic [15:0] rec_real [$];
  logic [15:0] rec_imag [$];
  logic        rec_last [$];
  logic        rec_install [$];
  logic        rec_ostall [$];
  int          accepted;

  fft_out_reorder #(.N(16), .LOG2N(4), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_push    (in_push),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_stall   (in_stall),
    .out_push_F (out_push_F),
    .out_real_F (out_real_F),
    .out_imag_F (out_imag_F),
    .out_last_F (out_last_F),
    .out_stall  (out_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs ncyc cycles: records outputs each cycle at the falling edge, then drives the next inputs.
  task automatic run(input int ncyc, input int stall_mode, input bit force_push);
    rec_push.delete(); rec_real.delete(); rec_imag.delete(); rec_last.delete();
    rec_install.delete(); rec_ostall.delete();
    accepted = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rec_push.push_back(out_push_F);
      rec_real.push_back(out_real_F);
      rec_imag.push_back(out_imag_F);
      rec_last.push_back(out_last_F);
      rec_install.push_back(in_stall);
      if (src_real.size() > 0 && (!in_stall || force_push)) begin
        in_push = 1'b1;
        in_real = src_real[0];
        in_imag = src_imag[0];
        if (!in_stall) begin
          void'(src_real.pop_front());
          void'(src_imag.pop_front());
          accepted++;
        end
      end else begin
        in_push = 1'b0;
      end
      case (stall_mode)
        0:       out_stall = 1'b0;
        1:       out_stall = 1'b1;
        default: out_stall = 1'($urandom_range(0, 1));
      endcase
      rec_ostall.push_back(out_stall);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_push   = 1'($urandom_range(0, 1));
      in_real   = 16'($urandom);
      in_imag   = 16'($urandom);
      out_stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ({out_push_F, out_last_F, in_stall, out_real_F, out_imag_F} !== 35'd0) begin
        bad++;
        $display("FAIL reset_outputs: got push=%0b last=%0b stall=%0b re=%0d im=%0d want all 0",
                 out_push_F, out_last_F, in_stall, out_real_F, out_imag_F);
      end
    end
    in_push = 1'b0; in_real = '0; in_imag = '0; out_stall = 1'b0;
    reset = 1'b1;
    run(10, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (rec_push[c] !== 1'b0 || rec_install[c] !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: got push=%0b stall=%0b want 0 0", c, rec_push[c], rec_install[c]);
      end
    end
  endtask

  task automatic test_reorder();
    for (int j = 0; j < 16; j++) begin
      src_real.push_back(16'(j));
      src_imag.push_back(16'(-j));
    end
    run(36, 0, 1'b0);
    total++;
    if (rec_push[16] !== 1'b0 || rec_push[17] !== 1'b1) begin
      bad++;
      $display("FAIL reorder_latency: got push@16=%0b push@17=%0b want 0 1", rec_push[16], rec_push[17]);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rec_push[17+k] !== 1'b1 || rec_real[17+k] !== 16'(tbl[k]) ||
          rec_imag[17+k] !== 16'(-tbl[k]) || rec_last[17+k] !== (k == 15)) begin
        bad++;
        $display("FAIL reorder k=%0d: got push=%0b re=%0d im=%0d last=%0b want 1 %0d %0d %0b",
                 k, rec_push[17+k], rec_real[17+k], rec_imag[17+k], rec_last[17+k],
                 tbl[k], 16'(-tbl[k]), (k == 15));
      end
    end
    total++;
    if (rec_push[33] !== 1'b0 || rec_real[33] !== 16'd15 || rec_last[33] !== 1'b1) begin
      bad++;
      $display("FAIL reorder_hold: got push=%0b re=%0d last=%0b want 0 15 1", rec_push[33], rec_real[33], rec_last[33]);
    end
  endtask

  task automatic test_back_to_back();
    int nstall;
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < 16; j++) begin
        src_real.push_back(16'(16*f + j));
        src_imag.push_back(16'(16'h4000 + 16*f + j));
      end
    run(86, 0, 1'b0);
    nstall = 0;
    for (int c = 0; c < 86; c++) if (rec_install[c] === 1'b1) nstall++;
    total++;
    if (nstall !== 0) begin
      bad++;
      $display("FAIL b2b_in_stall: got %0d stalled cycles want 0", nstall);
    end
    total++;
    if (rec_push[16] !== 1'b0 || rec_push[81] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_window: got push@16=%0b push@81=%0b want 0 0", rec_push[16], rec_push[81]);
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (rec_push[17+i] !== 1'b1 || rec_real[17+i] !== 16'(16*(i/16) + tbl[i%16]) ||
          rec_imag[17+i] !== 16'(16'h4000 + 16*(i/16) + tbl[i%16]) || rec_last[17+i] !== ((i % 16) == 15)) begin
        bad++;
        $display("FAIL b2b i=%0d: got push=%0b re=%0d last=%0b want 1 %0d %0b",
                 i, rec_push[17+i], rec_real[17+i], rec_last[17+i], 16*(i/16) + tbl[i%16], ((i % 16) == 15));
      end
    end
  endtask

  task automatic test_back_pressure();
    int npush, first_last;
    for (int j = 0; j < 48; j++) begin
      src_real.push_back(16'(16'h1000 + j));
      src_imag.push_back(16'(16'h2000 + j));
    end
    run(40, 1, 1'b1);
    npush = 0;
    for (int c = 0; c < 40; c++) if (rec_push[c] === 1'b1) npush++;
    total++;
    if (npush !== 0) begin
      bad++;
      $display("FAIL bp_no_output: got %0d outputs want 0", npush);
    end
    total++;
    if (rec_install[31] !== 1'b0 || rec_install[32] !== 1'b1 || rec_install[39] !== 1'b1) begin
      bad++;
      $display("FAIL bp_in_stall: got @31=%0b @32=%0b @39=%0b want 0 1 1", rec_install[31], rec_install[32], rec_install[39]);
    end
    total++;
    if (accepted !== 32) begin
      bad++;
      $display("FAIL bp_accepted: got %0d want 32", accepted);
    end
    src_real.delete(); src_imag.delete();
    run(40, 0, 1'b0);
    first_last = -1;
    for (int c = 39; c >= 0; c--) if (rec_push[c] === 1'b1 && rec_last[c] === 1'b1 && c < 20) first_last = c;
    total++;
    if (first_last !== 16) begin
      bad++;
      $display("FAIL bp_frame1_last: got cycle %0d want 16", first_last);
    end
    total++;
    if (rec_install[15] !== 1'b1 || rec_install[16] !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall_release: got @15=%0b @16=%0b want 1 0", rec_install[15], rec_install[16]);
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (rec_push[1+i] !== 1'b1 || rec_real[1+i] !== 16'(16'h1000 + 16*(i/16) + tbl[i%16]) ||
          rec_imag[1+i] !== 16'(16'h2000 + 16*(i/16) + tbl[i%16])) begin
        bad++;
        $display("FAIL bp_drain i=%0d: got push=%0b re=%0h im=%0h want 1 %0h %0h", i, rec_push[1+i],
                 rec_real[1+i], rec_imag[1+i], 16'h1000 + 16*(i/16) + tbl[i%16], 16'h2000 + 16*(i/16) + tbl[i%16]);
      end
    end
    total++;
    if (rec_push[33] !== 1'b0) begin
      bad++;
      $display("FAIL bp_extra_output: got push=%0b want 0", rec_push[33]);
    end
  endtask

  task automatic test_random_stall();
    int n, viol;
    for (int f = 0; f < 20; f++)
      for (int j = 0; j < 16; j++) begin
        src_real.push_back(16'(16*f + j));
        src_imag.push_back(16'(16'h8000 + 16*f + j));
      end
    run(1400, 2, 1'b0);
    n = 0;
    viol = 0;
    for (int c = 0; c < 1400; c++) begin
      if (rec_push[c] === 1'b1) begin
        if (c > 0 && rec_ostall[c-1] === 1'b1) viol++;
        if (n < 320) begin
          total++;
          if (rec_real[c] !== 16'(16*(n/16) + tbl[n%16]) || rec_imag[c] !== 16'(16'h8000 + 16*(n/16) + tbl[n%16]) ||
              rec_last[c] !== ((n % 16) == 15)) begin
            bad++;
            $display("FAIL rand n=%0d: got re=%0d im=%0h last=%0b want %0d %0h %0b", n, rec_real[c], rec_imag[c],
                     rec_last[c], 16*(n/16) + tbl[n%16], 16'h8000 + 16*(n/16) + tbl[n%16], ((n % 16) == 15));
          end
        end
        n++;
      end
    end
    total++;
    if (n !== 320) begin
      bad++;
      $display("FAIL rand_count: got %0d outputs want 320", n);
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL rand_stall_obeyed: got %0d outputs after stalled cycles want 0", viol);
    end
    out_stall = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n;
    for (int j = 0; j < 7; j++) begin
      src_real.push_back(16'(16'h0777));
      src_imag.push_back(16'(16'h0777));
    end
    run(9, 0, 1'b0);
    @(negedge clk);
    in_push = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (out_push_F !== 1'b0 || in_stall !== 1'b0 || out_real_F !== 16'd0) begin
      bad++;
      $display("FAIL midreset_async: got push=%0b stall=%0b re=%0d want 0 0 0", out_push_F, in_stall, out_real_F);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 16; j++) begin
      src_real.push_back(16'(100 + j));
      src_imag.push_back(16'(200 + j));
    end
    run(40, 0, 1'b0);
    n = 0;
    for (int c = 0; c < 40; c++) if (rec_push[c] === 1'b1) n++;
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL midreset_count: got %0d outputs want 16", n);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rec_push[17+k] !== 1'b1 || rec_real[17+k] !== 16'(100 + tbl[k]) || rec_imag[17+k] !== 16'(200 + tbl[k]) ||
          rec_last[17+k] !== (k == 15)) begin
        bad++;
        $display("FAIL midreset k=%0d: got push=%0b re=%0d im=%0d last=%0b want 1 %0d %0d %0b", k, rec_push[17+k],
                 rec_real[17+k], rec_imag[17+k], rec_last[17+k], 100 + tbl[k], 200 + tbl[k], (k == 15));
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_push = 1'b0; in_real = '0; in_imag = '0; out_stall = 1'b0;
    test_reset();
    test_reorder();
    test_back_to_back();
    test_back_pressure();
    test_random_stall();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
